// File: rtl/ram_streamer_if.sv
// ram_streamer_if
//   Bundles the RAM initiator port and the outgoing valid/ready word stream
//   used by ram_streamer.
//
//   Parameters:
//     W  data word width (matches the RAM word)
//     K  RAM address width (2**K words)
//
//   Signals:
//     ram_address  streamer -> RAM   read/write address
//     ram_in       streamer -> RAM   write data
//     ram_load     streamer -> RAM   write enable
//     ram_out      RAM -> streamer   combinational read data for ram_address
//     m_valid      streamer -> sink  stream word valid
//     m_ready      sink -> streamer  sink accepts the word
//     m_data       streamer -> sink  stream word
//
//   Modports:
//     master  the streamer side (drives the RAM port and the stream)
//     slave   the RAM/sink side
interface ram_streamer_if #(
    parameter int W = 16,
    parameter int K = 14
);
    logic [K-1:0] ram_address;
    logic [W-1:0] ram_in;
    logic         ram_load;
    logic [W-1:0] ram_out;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;

    modport master (
        output ram_address,
        output ram_in,
        output ram_load,
        input  ram_out,
        output m_valid,
        input  m_ready,
        output m_data
    );

    modport slave (
        input  ram_address,
        input  ram_in,
        input  ram_load,
        output ram_out,
        input  m_valid,
        output m_ready,
        input  m_data
    );
endinterface

// File: rtl/ram_streamer.sv
// ram_streamer
//   Sequential read-out engine for the 2**K-word RAM port. A start command
//   latches a base address and a word count; the engine then fetches each
//   word from the RAM's combinational read data and presents it on a
//   valid/ready stream, honouring back-pressure. Addresses wrap modulo 2**K.
//
//   Optional feature (macro RAM_STREAMER_CLEAR_EN): destructive read. Each
//   word is written back as zero in the same cycle it is handed off on the
//   stream. Without the macro the RAM is never written.
//
//   Ports:
//     clk     rising-edge clock shared with the RAM
//     rst_n   asynchronous active-low reset
//     start   one-cycle command strobe, only honoured while idle
//     base    first address, sampled with start
//     count   number of words, sampled with start; saturates at 2**K
//     busy    high while a transfer is in progress (registered)
//     done    one-cycle completion pulse (registered)
//     bus     RAM port and output stream (ram_streamer_if master modport)
module ram_streamer #(
    parameter int W = 16,
    parameter int K = 14
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [K-1:0]   base,
    input  logic [K:0]     count,
    output logic           busy,
    output logic           done,
    ram_streamer_if.master bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] SEND  = 2'd2;

    localparam logic [K:0]   MAX_WORDS = {1'b1, {K{1'b0}}};
    localparam logic [K:0]   REM_ONE   = {{K{1'b0}}, 1'b1};
    localparam logic [K-1:0] ADDR_ONE  = {{(K-1){1'b0}}, 1'b1};

    logic [1:0]   state;
    logic [K-1:0] addr;
    logic [K:0]   remaining;
    logic [W-1:0] data_q;
    logic [K:0]   count_sat;
    logic         handshake;

    // A request larger than the whole RAM would otherwise stream some words
    // twice; clamp it to exactly one pass over the address space.
    assign count_sat = (count > MAX_WORDS) ? MAX_WORDS : count;

    // A word leaves the engine only while it is being offered in SEND.
    assign handshake = (state == SEND) && bus.m_ready;

    // Main sequencer: IDLE waits for a command, FETCH captures the RAM read
    // data for the current address, SEND holds that word on the stream until
    // the sink takes it. busy and done are registered here so they change on
    // the same edge as the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            data_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (count == '0) begin
                            // Empty request: acknowledge without touching the RAM.
                            done <= 1'b1;
                        end else begin
                            addr      <= base;
                            remaining <= count_sat;
                            busy      <= 1'b1;
                            state     <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    data_q <= bus.ram_out;
                    state  <= SEND;
                end
                SEND: begin
                    if (handshake) begin
                        // K-bit add wraps from the top word back to address 0.
                        addr      <= addr + ADDR_ONE;
                        remaining <= remaining - REM_ONE;
                        if (remaining == REM_ONE) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // The address register drives the RAM in every state, so the address is
    // still valid during SEND for the optional write-back of a cleared word.
    assign bus.ram_address = addr;
    assign bus.ram_in      = '0;
    assign bus.m_valid     = (state == SEND);
    assign bus.m_data      = data_q;

`ifdef RAM_STREAMER_CLEAR_EN
    // Zero the word being handed off, at the same edge as the handshake.
    assign bus.ram_load = handshake;
`else
    assign bus.ram_load = 1'b0;
`endif

endmodule

// File: tb/tb_ram_streamer.sv
// tb_ram_streamer
//   Directed testbench for ram_streamer. A behavioural RAM with combinational
//   read is attached to the RAM port. Expected stream words (data, address and,
//   where fixed, the cycle of the handshake) are pushed into a scoreboard when
//   a command is issued; an independent monitor pops and compares on every
//   stream handshake. Cycle numbering: the start strobe is sampled at edge 0
//   and cycle k is the period following edge k-1.
module tb_ram_streamer;

    typedef struct {
        logic [15:0] data;
        logic [13:0] addr;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [13:0] base;
    logic [14:0] count;
    logic        busy;
    logic        done;

    logic [15:0] mem [0:16383];

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   t0          = 0;
    exp_t sb[$];

    ram_streamer_if #(.W(16), .K(14)) bus ();

    ram_streamer #(.W(16), .K(14)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .base  (base),
        .count (count),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running edge counter used to time handshakes and done pulses.
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: combinational read, write at the rising edge.
    assign bus.ram_out = mem[bus.ram_address];

    always @(posedge clk) begin
        if (bus.ram_load) mem[bus.ram_address] = bus.ram_in;
    end

    // One comparison; reports the actual and required values on a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    // Issue a command; returns just after edge 0, i.e. at the start of cycle 1.
    task automatic applyStimulus(input logic [13:0] b, input logic [14:0] n);
        @(posedge clk);
        #1;
        start = 1'b1;
        base  = b;
        count = n;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0    = cyc - 1;
    endtask

    task automatic expectWord(input logic [15:0] d, input logic [13:0] a, input int c);
        exp_t e;
        e.data = d;
        e.addr = a;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    // Bounded wait for the done pulse, checking when it arrives.
    task automatic waitDone(input int exp_cycle);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                checkOutput("done_cycle", cyc - t0, exp_cycle);
                checkOutput("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL done_timeout: got no done pulse, required one in cycle %0d",
                     exp_cycle);
        end
    endtask

    // Stream monitor: checks every handshake against the scoreboard and
    // checks the RAM write port in every cycle out of reset.
    always @(negedge clk) begin
        exp_t e;
        logic exp_load;
        if (rst_n) begin
`ifdef RAM_STREAMER_CLEAR_EN
            exp_load = bus.m_valid && bus.m_ready;
`else
            exp_load = 1'b0;
`endif
            checkOutput("ram_load", {31'd0, bus.ram_load}, {31'd0, exp_load});
            checkOutput("ram_in", {16'd0, bus.ram_in}, 32'd0);
            if (bus.m_valid && bus.m_ready) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_word: got 0x%0h at 0x%0h, required no word",
                             bus.m_data, bus.ram_address);
                end else begin
                    e = sb.pop_front();
                    checkOutput("m_data", {16'd0, bus.m_data}, {16'd0, e.data});
                    checkOutput("word_address", {18'd0, bus.ram_address}, {18'd0, e.addr});
                    if (e.cyc >= 0) checkOutput("handshake_cycle", cyc - t0, e.cyc);
                end
            end
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
        checkOutput({tag, "_m_valid"}, {31'd0, bus.m_valid}, 32'd0);
        checkOutput({tag, "_m_data"}, {16'd0, bus.m_data}, 32'd0);
        checkOutput({tag, "_ram_address"}, {18'd0, bus.ram_address}, 32'd0);
        checkOutput({tag, "_ram_load"}, {31'd0, bus.ram_load}, 32'd0);
        checkOutput({tag, "_ram_in"}, {16'd0, bus.ram_in}, 32'd0);
    endtask

    task automatic loadBasic();
        mem[14'h0010] = 16'h1111;
        mem[14'h0011] = 16'h2222;
        mem[14'h0012] = 16'h3333;
        mem[14'h0013] = 16'hABCD;
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        base        = '0;
        count       = '0;
        bus.m_ready = 1'b0;
        for (int i = 0; i < 16384; i++) mem[i] = 16'h0000;

        // Reset state.
        #2;
        checkAllZero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic stream of three words with the sink always ready.
        $display("[TB] basic stream");
        loadBasic();
        bus.m_ready = 1'b1;
        expectWord(16'h1111, 14'h0010, 2);
        expectWord(16'h2222, 14'h0011, 4);
        expectWord(16'h3333, 14'h0012, 6);
        applyStimulus(14'h0010, 15'd3);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checkOutput($sformatf("basic_busy_c%0d", k), {31'd0, busy},
                        (k <= 6) ? 32'd1 : 32'd0);
            checkOutput($sformatf("basic_done_c%0d", k), {31'd0, done},
                        (k == 7) ? 32'd1 : 32'd0);
        end
        checkOutput("basic_sb_empty", sb.size(), 32'd0);
`ifdef RAM_STREAMER_CLEAR_EN
        checkOutput("clear_0010", {16'd0, mem[14'h0010]}, 32'h0000);
        checkOutput("clear_0011", {16'd0, mem[14'h0011]}, 32'h0000);
        checkOutput("clear_0012", {16'd0, mem[14'h0012]}, 32'h0000);
`else
        checkOutput("keep_0010", {16'd0, mem[14'h0010]}, 32'h1111);
        checkOutput("keep_0011", {16'd0, mem[14'h0011]}, 32'h2222);
        checkOutput("keep_0012", {16'd0, mem[14'h0012]}, 32'h3333);
`endif
        checkOutput("keep_0013", {16'd0, mem[14'h0013]}, 32'hABCD);

        // Back-pressure: sink stalls for cycles 2..6.
        $display("[TB] back-pressure");
        loadBasic();
        bus.m_ready = 1'b0;
        expectWord(16'h1111, 14'h0010, 7);
        expectWord(16'h2222, 14'h0011, 9);
        expectWord(16'h3333, 14'h0012, 11);
        applyStimulus(14'h0010, 15'd3);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                checkOutput($sformatf("bp_valid_c%0d", k), {31'd0, bus.m_valid}, 32'd1);
                checkOutput($sformatf("bp_data_c%0d", k), {16'd0, bus.m_data}, 32'h1111);
                checkOutput($sformatf("bp_addr_c%0d", k), {18'd0, bus.ram_address}, 32'h0010);
            end
        end
        @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
        waitDone(12);

        // Address wrap across the top of the RAM.
        $display("[TB] wrap");
        mem[14'h3FFE] = 16'hA0A0;
        mem[14'h3FFF] = 16'hB1B1;
        mem[14'h0000] = 16'hC2C2;
        mem[14'h0001] = 16'hD3D3;
        expectWord(16'hA0A0, 14'h3FFE, 2);
        expectWord(16'hB1B1, 14'h3FFF, 4);
        expectWord(16'hC2C2, 14'h0000, 6);
        expectWord(16'hD3D3, 14'h0001, 8);
        applyStimulus(14'h3FFE, 15'd4);
        waitDone(9);

        // Zero count: done in cycle 1, nothing streamed.
        $display("[TB] zero count");
        applyStimulus(14'h0020, 15'd0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checkOutput($sformatf("zero_done_c%0d", k), {31'd0, done},
                        (k == 1) ? 32'd1 : 32'd0);
            checkOutput($sformatf("zero_valid_c%0d", k), {31'd0, bus.m_valid}, 32'd0);
            checkOutput($sformatf("zero_busy_c%0d", k), {31'd0, busy}, 32'd0);
        end

        // Overlapping start while busy is ignored.
        $display("[TB] overlapping start");
        loadBasic();
        mem[14'h0030] = 16'h5A5A;
        expectWord(16'h1111, 14'h0010, 2);
        expectWord(16'h2222, 14'h0011, 4);
        expectWord(16'h3333, 14'h0012, 6);
        applyStimulus(14'h0010, 15'd3);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        start = 1'b1;
        base  = 14'h0030;
        count = 15'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(7);
        repeat (6) @(negedge clk);
        checkOutput("overlap_idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("overlap_sb_empty", sb.size(), 32'd0);

        // Reset in cycle 3 of a five-word transfer.
        $display("[TB] reset mid-transfer");
        mem[14'h0040] = 16'h4040;
        mem[14'h0041] = 16'h4141;
        expectWord(16'h4040, 14'h0040, 2);
        applyStimulus(14'h0040, 15'd5);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkAllZero("midrst");
        repeat (3) begin
            @(negedge clk);
            checkOutput("midrst_no_done", {31'd0, done}, 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("midrst_sb_empty", sb.size(), 32'd0);
        @(negedge clk);
        checkOutput("after_rst_done", {31'd0, done}, 32'd0);
        checkOutput("after_rst_busy", {31'd0, busy}, 32'd0);

        mem[14'h0050] = 16'h7E57;
        mem[14'h0051] = 16'h0BAD;
        expectWord(16'h7E57, 14'h0050, 2);
        expectWord(16'h0BAD, 14'h0051, 4);
        applyStimulus(14'h0050, 15'd2);
        waitDone(5);
        checkOutput("final_sb_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_streamer.md
# ram_streamer

Sequential read-out engine that sits on the initiator side of the 16K-word RAM port (address, in, load, out). On a start command it walks a contiguous address range, samples each word from the RAM's combinational read data, and delivers it on a valid/ready stream for debug dumps, screen scan-out or checksum logic. It replaces testbench backdoor reads with a synthesizable reader that honours back-pressure.

## Interface
- W, 16, data word width; matches the RAM word.
- K, 14, address width; the RAM holds 2**K words.
- clk  input  1  rising-edge clock shared with the RAM.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle command strobe; sampled only in IDLE.
- base  input  K  first address, sampled with start.
- count  input  K+1  words to stream, sampled with start; values above 2**K saturate to 2**K.
- busy  output  1  high while a transfer is in progress.
- done  output  1  one-cycle pulse when a transfer completes.
- ram_address  output  K  drives the RAM address port.
- ram_in  output  W  drives the RAM write data; always 0.
- ram_load  output  1  drives the RAM write enable.
- ram_out  input  W  combinational RAM read data for ram_address.
- m_valid  output  1  stream word valid.
- m_ready  input  1  downstream accepts word.
- m_data  output  W  stream word.

## Operation
- States: IDLE, FETCH, SEND.
- IDLE: busy=0, m_valid=0. On start with count=0: stay in IDLE and pulse done on the next cycle. On start with count>0: latch addr=base, remaining=min(count,2**K), go to FETCH.
- FETCH: ram_address=addr; data_q<=ram_out at the clock edge; go to SEND.
- SEND: m_valid=1, m_data=data_q, ram_address still addr. On m_valid&&m_ready (handshake): addr<=addr+1 modulo 2**K; remaining<=remaining-1. If remaining was 1, go to IDLE and pulse done. Otherwise go to FETCH.
- start is ignored while busy; base and count changes mid-transfer have no effect.
- Address wrap: 2**K-1 is followed by 0, with no error.
- m_data is stable and m_valid stays high until the handshake; m_valid never drops without a handshake.
- ram_load=0 in all states unless the Configuration macro is defined.

## Timing
- Reset (asynchronous, immediate): state=IDLE; busy=0, done=0, m_valid=0, m_data=0, ram_address=0, ram_load=0, ram_in=0, remaining=0.
- start is sampled at edge 0. FETCH occupies cycle 1. m_valid is first high in cycle 2.
- With m_ready held high, throughput is one word per 2 cycles. An N-word transfer has its last handshake in cycle 2N. done is high in cycle 2N+1, in the same cycle that busy falls.
- A count=0 start at edge 0 gives done in cycle 1, with no m_valid.
- done and busy are registered outputs.
- Reset asserted mid-transfer aborts immediately: no done pulse, and no further RAM writes.
- A new start is accepted in the cycle done is high, because the state is already IDLE.

## Configuration
- RAM_STREAMER_CLEAR_EN defined: destructive read. On each SEND handshake cycle, ram_load=1 with ram_address=addr and ram_in=0, so the word is zeroed at that edge. This write goes to the word just delivered. ram_load is 0 in every other cycle.
- RAM_STREAMER_CLEAR_EN undefined: ram_load is tied to 0 and RAM contents are never modified.

## Test plan
- Basic stream: RAM[0x0010..0x0012] = 0x1111, 0x2222, 0x3333; start with base=0x0010, count=3, m_ready=1. Required: words 0x1111, 0x2222, 0x3333 in order, handshakes in cycles 2, 4 and 6, done in cycle 7, busy high for cycles 1–6.
- Back-pressure: same setup with m_ready=0 for cycles 2–6. Required: m_valid=1 and m_data=0x1111 held steady, ram_address=0x0010, no progress; the first handshake occurs in cycle 7.
- Wrap: RAM[0x3FFE], RAM[0x3FFF], RAM[0], RAM[1] = A, B, C, D; start with base=0x3FFE, count=4. Required: stream A, B, C, D, and ram_address sequence 0x3FFE, 0x3FFF, 0x0000, 0x0001.
- Zero count and overlapping start: count=0 gives done in cycle 1 and m_valid never high. A start pulsed while busy is ignored, so the original transfer completes unchanged.
- Reset mid-op: assert rst_n=0 in cycle 3 of a 5-word transfer. Required: all outputs 0 immediately, no done pulse, and a fresh start then works normally.
- Clear feature: with RAM_STREAMER_CLEAR_EN, after streaming 3 words at 0x0010, RAM[0x0010..0x0012] read 0 and RAM[0x0013] is unchanged. Without the macro, all locations keep their values and ram_load stays 0 throughout.
